// File: rtl/dct_quant_rle_if.sv
// ---------------------------------------------------------------------------
// dct_quant_rle_if
//   Bundles the coefficient input stream and the token output handshake of
//   the DCT quantizer / run-length encoder.
//
//   Coefficient side : coef_valid, coef_in, blk_sof
//   Token side       : out_valid, out_ready, out_run, out_level, out_eob
//   Status           : overflow (sticky token-drop flag)
//
//   modport master : the environment (DCT output register + token consumer)
//   modport slave  : the quantizer / RLE block itself
// ---------------------------------------------------------------------------
interface dct_quant_rle_if #(
  parameter int COEF_W = 19,
  parameter int LVL_W  = 8,
  parameter int N_COEF = 8
);
  localparam int IDX_W = $clog2(N_COEF);

  logic                     coef_valid;
  logic signed [COEF_W-1:0] coef_in;
  logic                     blk_sof;

  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_run;
  logic signed [LVL_W-1:0]  out_level;
  logic                     out_eob;
  logic                     overflow;

  modport master (
    output coef_valid, coef_in, blk_sof, out_ready,
    input  out_valid, out_run, out_level, out_eob, overflow
  );

  modport slave (
    input  coef_valid, coef_in, blk_sof, out_ready,
    output out_valid, out_run, out_level, out_eob, overflow
  );
endinterface

// File: rtl/dct_quant_rle.sv
// ---------------------------------------------------------------------------
// dct_quant_rle
//   Quantizes signed DCT coefficients (rounded right shift, half away from
//   zero, saturated to a symmetric level range) and run-length encodes each
//   N_COEF-coefficient block into (run, level, eob) tokens held in a small
//   FIFO behind a valid/ready handshake.
//
//   Ports:
//     clk    : clock, all logic on the rising edge
//     rst_n  : synchronous reset, ACTIVE HIGH despite the name
//     bus    : dct_quant_rle_if.slave
//              coef_valid/coef_in/blk_sof  - coefficient stream in
//              out_valid/out_ready         - token handshake
//              out_run/out_level/out_eob   - head token (0 while empty)
//              overflow                    - sticky, a token was dropped
//
//   Pipeline: coefficient sampled -> stage 1 register (level, index, sof)
//             -> stage 2 RLE decision pushes straight into the FIFO, so a
//             coefficient at cycle t is visible on the outputs at t+2.
// ---------------------------------------------------------------------------
module dct_quant_rle #(
  parameter int COEF_W     = 19,
  parameter int LVL_W      = 8,
  parameter int Q_SHIFT    = 4,
  parameter int N_COEF     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dct_quant_rle_if.slave bus
);

  localparam int IDX_W   = $clog2(N_COEF);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TOK_W   = IDX_W + LVL_W + 1;
  localparam int SUM_W   = COEF_W + 1;
  localparam int LVL_MAX = 2**(LVL_W-1) - 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COEF - 1);

  // -------------------------------------------------------------------------
  // Stage 1: quantizer (combinational part)
  // -------------------------------------------------------------------------
  logic              w_neg;
  logic [COEF_W-1:0] w_mag;
  logic [SUM_W-1:0]  w_rnd;
  logic [SUM_W-1:0]  w_q;
  logic [LVL_W-1:0]  w_sat;
  logic [LVL_W-1:0]  w_lvl;
  logic [IDX_W-1:0]  w_idx;

  logic [IDX_W-1:0]  r_idx;
  logic              r_s1_valid;
  logic [LVL_W-1:0]  r_s1_lvl;
  logic [IDX_W-1:0]  r_s1_idx;
  logic              r_s1_sof;

  always_comb begin
    w_neg = bus.coef_in[COEF_W-1];
    // Negating the most negative input wraps to 2^(COEF_W-1), which is the
    // correct magnitude when read as unsigned.
    w_mag = w_neg ? COEF_W'(-bus.coef_in) : COEF_W'(bus.coef_in);
    // One extra bit so adding the rounding constant can never wrap.
    w_rnd = {1'b0, w_mag} + SUM_W'(2**(Q_SHIFT-1));
    w_q   = w_rnd >> Q_SHIFT;
    w_sat = (w_q > SUM_W'(LVL_MAX)) ? LVL_W'(LVL_MAX) : w_q[LVL_W-1:0];
    // Negating a zero magnitude yields zero, so -0 never appears.
    w_lvl = w_neg ? (-w_sat) : w_sat;
    // blk_sof pins this coefficient to index 0 regardless of the counter.
    w_idx = bus.blk_sof ? '0 : r_idx;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_idx      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_lvl   <= '0;
      r_s1_idx   <= '0;
      r_s1_sof   <= 1'b0;
    end else begin
      r_s1_valid <= bus.coef_valid;
      if (bus.coef_valid) begin
        r_s1_lvl <= w_lvl;
        r_s1_idx <= w_idx;
        r_s1_sof <= bus.blk_sof;
        r_idx    <= (w_idx == IDX_LAST) ? '0 : w_idx + IDX_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: run-length decision, at most one push per coefficient
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] r_run;
  logic [IDX_W-1:0] w_run_eff;
  logic             w_last;
  logic             w_nz;
  logic             w_push;
  logic [TOK_W-1:0] w_tok;

  always_comb begin
    // A start-of-block coefficient sees a cleared run, discarding any zeros
    // counted for an abandoned block.
    w_run_eff = r_s1_sof ? '0 : r_run;
    w_last    = (r_s1_idx == IDX_LAST);
    w_nz      = (r_s1_lvl != '0);
    w_push    = r_s1_valid && (w_last || w_nz);
    // A zero in the last slot emits a bare EOB; the trailing zeros are
    // implied, so the run field is 0 rather than the counted run.
    w_tok     = {(w_last && !w_nz) ? IDX_W'(0) : w_run_eff, r_s1_lvl, w_last};
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_run <= '0;
    end else if (r_s1_valid) begin
      r_run <= (!w_last && !w_nz) ? w_run_eff + IDX_W'(1) : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Token FIFO: pointers carry one wrap bit to tell full from empty.
  // Read is asynchronous so the head token is on the outputs as soon as it
  // is written.
  // -------------------------------------------------------------------------
  logic [TOK_W-1:0] r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic             r_ovf;

  logic [CNT_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [TOK_W-1:0] w_head;

  always_comb begin
    w_count   = r_wr_ptr - r_rd_ptr;
    w_empty   = (w_count == '0);
    w_full    = (w_count == CNT_W'(FIFO_DEPTH));
    w_pop     = !w_empty && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves in that cycle.
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
    w_head    = r_mem[r_rd_ptr[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n && w_push_ok) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_tok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + CNT_W'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + CNT_W'(1);
      if (w_drop)    r_ovf    <= 1'b1;
    end
  end

  // Data outputs are forced to 0 while empty so the interface reads all
  // zero straight after reset, before the storage holds anything defined.
  assign bus.out_valid = !w_empty;
  assign bus.out_run   = w_empty ? '0 : w_head[TOK_W-1 -: IDX_W];
  assign bus.out_level = w_empty ? '0 : w_head[LVL_W:1];
  assign bus.out_eob   = w_empty ? 1'b0 : w_head[0];
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_dct_quant_rle.sv
// ---------------------------------------------------------------------------
// tb_dct_quant_rle
//   Directed block scenarios plus randomized traffic for dct_quant_rle.
//   A token-level reference model (integer quantizer, run counter over block
//   positions, bounded token queue) predicts the output interface each cycle.
//   Inputs are driven on the falling edge, outputs compared on the falling
//   edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_dct_quant_rle;

  localparam int COEF_W     = 19;
  localparam int LVL_W      = 8;
  localparam int Q_SHIFT    = 4;
  localparam int N_COEF     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int IDX_W      = $clog2(N_COEF);
  localparam int TW         = IDX_W + LVL_W + 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dct_quant_rle_if #(.COEF_W(COEF_W), .LVL_W(LVL_W), .N_COEF(N_COEF)) bus ();

  dct_quant_rle #(
    .COEF_W(COEF_W), .LVL_W(LVL_W), .Q_SHIFT(Q_SHIFT),
    .N_COEF(N_COEF), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state
  logic [TW-1:0] mq[$];
  logic [TW-1:0] got[$];
  logic [TW-1:0] eq[$];
  bit            m_ovf;
  int            m_idx;
  int            m_run;
  bit            pend_v;
  logic [TW-1:0] pend_tok;
  int            blk[8];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] tok(input int r, input int l, input bit e);
    return {IDX_W'(r), LVL_W'(l), e};
  endfunction

  function automatic int quant(input int c);
    int m, q;
    m = (c < 0) ? -c : c;
    q = (m + (1 << (Q_SHIFT - 1))) >> Q_SHIFT;
    if (q > (1 << (LVL_W - 1)) - 1) q = (1 << (LVL_W - 1)) - 1;
    return (c < 0) ? -q : q;
  endfunction

  // Token-level behaviour at one rising edge: the token produced by the
  // coefficient of the previous cycle competes for FIFO space with the pop
  // of this cycle; this cycle's coefficient produces the next pending token.
  task automatic model_edge(input bit v, input int c, input bit sof, input bit rdy, input bit rst);
    bit pop, acc;
    int i, l;
    if (rst) begin
      mq.delete();
      m_ovf  = 0;
      m_idx  = 0;
      m_run  = 0;
      pend_v = 0;
    end else begin
      pop = (mq.size() != 0) && rdy;
      acc = pend_v && ((mq.size() < FIFO_DEPTH) || pop);
      if (pend_v && !acc) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(pend_tok);
      pend_v = 0;
      if (v) begin
        i = sof ? 0 : m_idx;
        if (sof) m_run = 0;
        l = quant(c);
        m_idx = (i + 1) % N_COEF;
        if (i < N_COEF - 1) begin
          if (l == 0) m_run++;
          else begin
            pend_v = 1; pend_tok = tok(m_run, l, 1'b0); m_run = 0;
          end
        end else begin
          pend_v   = 1;
          pend_tok = (l != 0) ? tok(m_run, l, 1'b1) : tok(0, 0, 1'b1);
          m_run    = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    check_val("out_valid", bus.out_valid, mq.size() != 0);
    check_val("overflow", bus.overflow, m_ovf);
    if (mq.size() != 0) begin
      check_val("out_run", bus.out_run, mq[0][TW-1 -: IDX_W]);
      check_val("out_level", $unsigned(bus.out_level), mq[0][LVL_W:1]);
      check_val("out_eob", bus.out_eob, mq[0][0]);
    end
  endtask

  task automatic step(input bit v, input int c, input bit sof, input bit rdy, input bit rst);
    rst_n          = rst;
    bus.coef_valid = v;
    bus.coef_in    = COEF_W'(c);
    bus.blk_sof    = sof;
    bus.out_ready  = rdy;
    if (!rst && bus.out_valid && rdy) begin
      got.push_back({bus.out_run, bus.out_level, bus.out_eob});
      $display("token run=%0d level=%0d eob=%0d", bus.out_run, bus.out_level, bus.out_eob);
    end
    @(posedge clk);
    model_edge(v, c, sof, rdy, rst);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1000, 1'b1, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    check_val("rst_valid", bus.out_valid, 0);
    check_val("rst_run", bus.out_run, 0);
    check_val("rst_level", $unsigned(bus.out_level), 0);
    check_val("rst_eob", bus.out_eob, 0);
    check_val("rst_ovf", bus.overflow, 0);
    got.delete();
  endtask

  task automatic feed_block(input int gap, input bit rdy);
    for (int k = 0; k < N_COEF; k++) begin
      step(1'b1, blk[k], k == 0, rdy, 1'b0);
      for (int g = 1; g < gap; g++) step(1'b0, 0, 1'b0, rdy, 1'b0);
    end
  endtask

  task automatic compare_got(input string tag);
    check_val({tag, "_count"}, got.size(), eq.size());
    for (int k = 0; k < eq.size(); k++) begin
      if (k < got.size()) check_val(tag, got[k], eq[k]);
    end
    got.delete();
  endtask

  function automatic int rand_coef();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 4) return 0;
    if (sel < 7) return int'($urandom_range(0, 80)) - 40;
    if (sel < 9) begin
      case ($urandom_range(0, 8))
        0: return 262143;
        1: return -262144;
        2: return 2039;
        3: return -2040;
        4: return 2024;
        5: return 8;
        6: return -8;
        7: return 7;
        default: return -7;
      endcase
    end
    return int'($urandom_range(0, 524287)) - 262144;
  endfunction

  initial begin
    int len, gap;
    bit sof_en;

    rst_n = 1'b1; bus.coef_valid = 1'b0; bus.coef_in = '0;
    bus.blk_sof = 1'b0; bus.out_ready = 1'b0;
    m_ovf = 0; m_idx = 0; m_run = 0; pend_v = 0; pend_tok = '0;

    // Basic block and pipeline latency
    do_reset();
    blk = '{40, 0, 0, -24, 0, 0, 0, 0};
    step(1'b1, blk[0], 1'b1, 1'b1, 1'b0);
    check_val("t1_lat_t1", bus.out_valid, 0);
    step(1'b1, blk[1], 1'b0, 1'b1, 1'b0);
    check_val("t1_lat_t2", bus.out_valid, 1);
    check_val("t1_lat_tok", {bus.out_run, bus.out_level, bus.out_eob}, tok(0, 3, 1'b0));
    for (int k = 2; k < N_COEF; k++) step(1'b1, blk[k], 1'b0, 1'b1, 1'b0);
    idle(4, 1'b1);
    eq = '{tok(0, 3, 1'b0), tok(2, -2, 1'b0), tok(0, 0, 1'b1)};
    compare_got("t1");

    // Rounding edges that land on zero
    blk = '{7, -7, 0, 0, 0, 0, 0, 0};
    feed_block(8, 1'b1); idle(4, 1'b1);
    eq = '{tok(0, 0, 1'b1)};
    compare_got("t2");

    // Run of seven zeros before the last coefficient
    blk = '{0, 0, 0, 0, 0, 0, 0, 100};
    feed_block(2, 1'b1); idle(4, 1'b1);
    eq = '{tok(7, 6, 1'b1)};
    compare_got("t3a");

    // Saturation and full-range extremes; last coefficient rounds to 0, so
    // the block closes with a bare EOB whose run is implied
    blk = '{8, -8, 262143, -262144, 0, 0, 0, 1};
    feed_block(1, 1'b1); idle(4, 1'b1);
    eq = '{tok(0, 1, 1'b0), tok(0, -1, 1'b0), tok(0, 127, 1'b0),
           tok(0, -127, 1'b0), tok(0, 0, 1'b1)};
    compare_got("t3b");

    // Overflow with the consumer stalled
    do_reset();
    blk = '{32, 32, 32, 32, 32, 32, 32, 32};
    feed_block(1, 1'b0); idle(3, 1'b0);
    check_val("t4_ovf_set", bus.overflow, 1);
    idle(8, 1'b1);
    eq = '{tok(0, 2, 1'b0), tok(0, 2, 1'b0), tok(0, 2, 1'b0), tok(0, 2, 1'b0)};
    compare_got("t4");
    check_val("t4_drained", bus.out_valid, 0);
    check_val("t4_ovf_sticky", bus.overflow, 1);

    // Push into a full FIFO while it pops: nothing is lost
    do_reset();
    for (int k = 0; k < N_COEF; k++) begin
      step(1'b1, 32, k == 0, k >= 5, 1'b0);
      if (k == 5) check_val("t5_ovf_at_full", bus.overflow, 0);
    end
    idle(6, 1'b1);
    check_val("t5_ovf_end", bus.overflow, 0);
    eq = '{tok(0, 2, 1'b0), tok(0, 2, 1'b0), tok(0, 2, 1'b0), tok(0, 2, 1'b0),
           tok(0, 2, 1'b0), tok(0, 2, 1'b0), tok(0, 2, 1'b0), tok(0, 2, 1'b1)};
    compare_got("t5");

    // Reset in the middle of a block
    do_reset();
    step(1'b1, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16, 1'b0, 1'b1, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    blk = '{16, 0, 0, 0, 0, 0, 0, 0};
    feed_block(2, 1'b1); idle(4, 1'b1);
    eq = '{tok(0, 1, 1'b0), tok(0, 0, 1'b1)};
    compare_got("t6a");

    // New start-of-block in the middle of a block
    step(1'b1, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16, 1'b0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 0, 1'b0, 1'b1, 1'b0);
    blk = '{0, 0, 0, 0, 0, 0, 0, 48};
    feed_block(1, 1'b1); idle(4, 1'b1);
    eq = '{tok(2, 1, 1'b0), tok(7, 3, 1'b1)};
    compare_got("t6b");

    // Randomized traffic against the model
    for (int b = 0; b < 80; b++) begin
      len    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : N_COEF;
      sof_en = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < len; k++) begin
        step(1'b1, rand_coef(), sof_en && (k == 0), $urandom_range(0, 9) < 7, 1'b0);
        gap = (b % 3 == 0) ? 0 : int'($urandom_range(0, 7));
        for (int g = 0; g < gap; g++)
          step(1'b0, 0, 1'b0, $urandom_range(0, 9) < 7, 1'b0);
      end
      if ($urandom_range(0, 15) == 0)
        step($urandom_range(0, 1) == 1, rand_coef(), 1'b0, 1'b1, 1'b1);
    end
    idle(12, 1'b1);
    check_val("rand_drained", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
